// File: rtl/tc_mi_to_st_arb_pkg.sv
// Shared traffic-cop bus widths, initiator count, arbiter state encodings and the
// initiator request payload used by the four-initiator / one-target Wishbone arbiter.
package tc_mi_to_st_arb_pkg;

  localparam int unsigned TC_AW  = 32;
  localparam int unsigned TC_DW  = 32;
  localparam int unsigned TC_BSW = TC_DW / 8;
  localparam int unsigned TC_NI  = 4;
  localparam int unsigned TC_IW  = 2;

  typedef enum logic [1:0] {
    TC_ARB_IDLE  = 2'd0,
    TC_ARB_GRANT = 2'd1,
    TC_ARB_TMO   = 2'd2
  } tc_arb_state_e;

  // Everything an initiator presents to the target apart from cyc
  typedef struct packed {
    logic              stb;
    logic [TC_AW-1:0]  adr;
    logic [TC_BSW-1:0] sel;
    logic              we;
    logic [TC_DW-1:0]  dat;
  } tc_wb_req_t;

endpackage

// File: rtl/tc_mi_to_st_arb_rr_arb.sv
// Combinational round-robin picker: first requester after i_last (mod TC_NI) wins,
// returned as a one-hot grant.
module tc_rr_arb
  import tc_mi_to_st_arb_pkg::*;
(
  input  logic [TC_NI-1:0] i_req,
  input  logic [TC_IW-1:0] i_last,
  output logic [TC_NI-1:0] o_gnt_c
);

  logic [TC_IW-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= TC_NI; k++) begin
      w_idx = i_last + TC_IW'(k);
      if (!w_found && i_req[w_idx]) begin
        o_gnt_c[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_mi_to_st_arb.sv
// Four-initiator to one-target Wishbone arbiter: round-robin grant held for a whole
// cyc, combinational pass-through from the registered owner, per-owner stall watchdog.
module tc_mi_to_st_arb
  import tc_mi_to_st_arb_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              i0_wb_cyc_i,
  input  logic              i0_wb_stb_i,
  input  logic [TC_AW-1:0]  i0_wb_adr_i,
  input  logic [TC_BSW-1:0] i0_wb_sel_i,
  input  logic              i0_wb_we_i,
  input  logic [TC_DW-1:0]  i0_wb_dat_i,
  output logic [TC_DW-1:0]  i0_wb_dat_o,
  output logic              i0_wb_ack_o,
  output logic              i0_wb_err_o,
  input  logic              i1_wb_cyc_i,
  input  logic              i1_wb_stb_i,
  input  logic [TC_AW-1:0]  i1_wb_adr_i,
  input  logic [TC_BSW-1:0] i1_wb_sel_i,
  input  logic              i1_wb_we_i,
  input  logic [TC_DW-1:0]  i1_wb_dat_i,
  output logic [TC_DW-1:0]  i1_wb_dat_o,
  output logic              i1_wb_ack_o,
  output logic              i1_wb_err_o,
  input  logic              i2_wb_cyc_i,
  input  logic              i2_wb_stb_i,
  input  logic [TC_AW-1:0]  i2_wb_adr_i,
  input  logic [TC_BSW-1:0] i2_wb_sel_i,
  input  logic              i2_wb_we_i,
  input  logic [TC_DW-1:0]  i2_wb_dat_i,
  output logic [TC_DW-1:0]  i2_wb_dat_o,
  output logic              i2_wb_ack_o,
  output logic              i2_wb_err_o,
  input  logic              i3_wb_cyc_i,
  input  logic              i3_wb_stb_i,
  input  logic [TC_AW-1:0]  i3_wb_adr_i,
  input  logic [TC_BSW-1:0] i3_wb_sel_i,
  input  logic              i3_wb_we_i,
  input  logic [TC_DW-1:0]  i3_wb_dat_i,
  output logic [TC_DW-1:0]  i3_wb_dat_o,
  output logic              i3_wb_ack_o,
  output logic              i3_wb_err_o,
  output logic              t0_wb_cyc_o,
  output logic              t0_wb_stb_o,
  output logic [TC_AW-1:0]  t0_wb_adr_o,
  output logic [TC_BSW-1:0] t0_wb_sel_o,
  output logic              t0_wb_we_o,
  output logic [TC_DW-1:0]  t0_wb_dat_o,
  input  logic [TC_DW-1:0]  t0_wb_dat_i,
  input  logic              t0_wb_ack_i,
  input  logic              t0_wb_err_i
);

  localparam bit               WD_EN   = (TO_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TO_CYCLES - 1 : 0);

  tc_arb_state_e    r_state, w_state_nxt;
  logic [TC_IW-1:0] r_owner, w_owner_nxt;
  logic [TC_IW-1:0] r_last, w_last_nxt;
  logic [CNT_W-1:0] r_wd_cnt, w_wd_cnt_nxt;

  logic [TC_NI-1:0] w_cyc;
  tc_wb_req_t       w_req [TC_NI];
  logic [TC_NI-1:0] w_gnt;
  logic [TC_IW-1:0] w_gnt_idx;
  tc_wb_req_t       w_own;
  logic             w_own_cyc;
  logic             w_act;
  logic             w_stall;

  tc_wb_req_t       w_t0;
  logic [TC_NI-1:0] w_ack_o;
  logic [TC_NI-1:0] w_err_o;
  logic [TC_DW-1:0] w_dat_o [TC_NI];

  assign w_cyc    = {i3_wb_cyc_i, i2_wb_cyc_i, i1_wb_cyc_i, i0_wb_cyc_i};
  assign w_req[0] = '{stb: i0_wb_stb_i, adr: i0_wb_adr_i, sel: i0_wb_sel_i, we: i0_wb_we_i, dat: i0_wb_dat_i};
  assign w_req[1] = '{stb: i1_wb_stb_i, adr: i1_wb_adr_i, sel: i1_wb_sel_i, we: i1_wb_we_i, dat: i1_wb_dat_i};
  assign w_req[2] = '{stb: i2_wb_stb_i, adr: i2_wb_adr_i, sel: i2_wb_sel_i, we: i2_wb_we_i, dat: i2_wb_dat_i};
  assign w_req[3] = '{stb: i3_wb_stb_i, adr: i3_wb_adr_i, sel: i3_wb_sel_i, we: i3_wb_we_i, dat: i3_wb_dat_i};

  tc_rr_arb u_rr_arb (
    .i_req   (w_cyc),
    .i_last  (r_last),
    .o_gnt_c (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < TC_NI; k++) begin
      if (w_gnt[k]) w_gnt_idx = TC_IW'(k);
    end
  end

  assign w_own     = w_req[r_owner];
  assign w_own_cyc = w_cyc[r_owner];
  assign w_act     = (r_state == TC_ARB_GRANT) && w_own_cyc;
  assign w_stall   = w_own.stb && !t0_wb_ack_i && !t0_wb_err_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state  <= TC_ARB_IDLE;
      r_owner  <= '0;
      r_last   <= TC_IW'(TC_NI - 1);
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end

  // Next state: arbitrate in IDLE, hold the owner for its whole cyc, watchdog in GRANT
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_wd_cnt_nxt = r_wd_cnt;
    case (r_state)
      TC_ARB_IDLE: begin
        w_wd_cnt_nxt = '0;
        if (|w_cyc) begin
          w_owner_nxt = w_gnt_idx;
          w_state_nxt = TC_ARB_GRANT;
        end
      end
      TC_ARB_GRANT: begin
        if (!w_own_cyc) begin
          w_state_nxt  = TC_ARB_IDLE;
          w_last_nxt   = r_owner;
          w_wd_cnt_nxt = '0;
        end else if (!w_stall) begin
          w_wd_cnt_nxt = '0;
        end else if (WD_EN && (r_wd_cnt == WD_LAST)) begin
          w_state_nxt  = TC_ARB_TMO;
          w_wd_cnt_nxt = '0;
        end else if (WD_EN) begin
          w_wd_cnt_nxt = r_wd_cnt + CNT_W'(1);
        end
      end
      TC_ARB_TMO: begin
        w_wd_cnt_nxt = '0;
        if (w_own_cyc) begin
          w_state_nxt = TC_ARB_GRANT;
        end else begin
          w_state_nxt = TC_ARB_IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: begin
        w_state_nxt  = TC_ARB_IDLE;
        w_wd_cnt_nxt = '0;
      end
    endcase
  end

  // Routing: only a live owner reaches the target; late target responses are dropped
  always_comb begin
    w_t0    = '0;
    w_ack_o = '0;
    w_err_o = '0;
    for (int unsigned k = 0; k < TC_NI; k++) w_dat_o[k] = '0;
    if (w_act) begin
      w_t0             = w_own;
      w_ack_o[r_owner] = t0_wb_ack_i;
      w_err_o[r_owner] = t0_wb_err_i;
      w_dat_o[r_owner] = t0_wb_dat_i;
    end else if (r_state == TC_ARB_TMO) begin
      w_err_o[r_owner] = 1'b1;
    end
  end

  assign t0_wb_cyc_o = w_act;
  assign t0_wb_stb_o = w_t0.stb;
  assign t0_wb_adr_o = w_t0.adr;
  assign t0_wb_sel_o = w_t0.sel;
  assign t0_wb_we_o  = w_t0.we;
  assign t0_wb_dat_o = w_t0.dat;

  assign i0_wb_dat_o = w_dat_o[0];
  assign i1_wb_dat_o = w_dat_o[1];
  assign i2_wb_dat_o = w_dat_o[2];
  assign i3_wb_dat_o = w_dat_o[3];
  assign {i3_wb_ack_o, i2_wb_ack_o, i1_wb_ack_o, i0_wb_ack_o} = w_ack_o;
  assign {i3_wb_err_o, i2_wb_err_o, i1_wb_err_o, i0_wb_err_o} = w_err_o;

endmodule
